// File: rtl/std_mem_d1_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : std_arb_pkg
//  Description : Shared types and constants for the std_mem_d1 two-client
//                round-robin arbiter (state encoding, requester count).
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package std_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT_W = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

endpackage : std_arb_pkg
`default_nettype wire

// File: rtl/std_mem_d1_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : std_mem_d1_arbiter_if
//  Description : Bundles both go/done client ports and the std_mem_d1 port
//                that the arbiter shares between them.
//  Ports       : p0_* / p1_*  client request, op, address, data, done
//                mem_*        memory addr0, write_data, write_en,
//                             read_data, done
//  Modports    : master - the arbiter (serves clients, drives memory)
//                slave  - the environment (clients plus the memory)
//  Revision    : 1.0  initial release
// ============================================================================
interface std_mem_d1_arbiter_if #(
    parameter int WIDTH    = 32,
    parameter int IDX_SIZE = 4
);
    logic                p0_go;
    logic                p0_write_en;
    logic [IDX_SIZE-1:0] p0_addr0;
    logic [WIDTH-1:0]    p0_write_data;
    logic [WIDTH-1:0]    p0_read_data;
    logic                p0_done;

    logic                p1_go;
    logic                p1_write_en;
    logic [IDX_SIZE-1:0] p1_addr0;
    logic [WIDTH-1:0]    p1_write_data;
    logic [WIDTH-1:0]    p1_read_data;
    logic                p1_done;

    logic [IDX_SIZE-1:0] mem_addr0;
    logic [WIDTH-1:0]    mem_write_data;
    logic                mem_write_en;
    logic [WIDTH-1:0]    mem_read_data;
    logic                mem_done;

    modport master (
        input  p0_go, p0_write_en, p0_addr0, p0_write_data,
        output p0_read_data, p0_done,
        input  p1_go, p1_write_en, p1_addr0, p1_write_data,
        output p1_read_data, p1_done,
        output mem_addr0, mem_write_data, mem_write_en,
        input  mem_read_data, mem_done
    );

    modport slave (
        output p0_go, p0_write_en, p0_addr0, p0_write_data,
        input  p0_read_data, p0_done,
        output p1_go, p1_write_en, p1_addr0, p1_write_data,
        input  p1_read_data, p1_done,
        input  mem_addr0, mem_write_data, mem_write_en,
        output mem_read_data, mem_done
    );

endinterface : std_mem_d1_arbiter_if
`default_nettype wire

// File: rtl/std_mem_d1_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : std_rr_arb2
//  Description : Combinational two-way pick. A lone requester always wins;
//                on a tie the client named by prio wins.
//  Ports       : req[1:0]  - request levels
//                prio      - client that wins a tie
//                gnt_valid - at least one request present
//                gnt_idx   - index of the winning client
//  Revision    : 1.0  initial release
// ============================================================================
module std_rr_arb2
    import std_arb_pkg::*;
(
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic               prio,
    output logic                    gnt_valid,
    output logic                    gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = prio;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule : std_rr_arb2
`default_nettype wire

// File: rtl/std_mem_d1_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : std_mem_d1_arbiter
//  Description : Round-robin arbiter sharing one single-ported std_mem_d1
//                between two Calyx go/done clients. Reads capture the
//                combinational memory output into a per-client register;
//                writes are held until the memory's registered done.
//                Each access ends with a one-cycle done to its owner.
//  Ports       : clk   - clock, all state on rising edge
//                reset - synchronous, active-low (0 = reset)
//                bus   - client and memory signals (master modport)
//  Revision    : 1.0  initial release
// ============================================================================
module std_mem_d1_arbiter
    import std_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int IDX_SIZE = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    std_mem_d1_arbiter_if.master  bus
);

    // Depth is informational only; it must still fit the address space.
    if (SIZE > (1 << IDX_SIZE)) begin : g_size_check
        $error("std_mem_d1_arbiter: SIZE exceeds 2**IDX_SIZE");
    end

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic                r_prio;
    logic                r_owner;
    logic                r_op;          // 1 = write
    logic [IDX_SIZE-1:0] r_addr;
    logic [WIDTH-1:0]    r_wdata;
    logic [WIDTH-1:0]    r_rdata0;
    logic [WIDTH-1:0]    r_rdata1;

    logic [NUM_REQ-1:0]  w_req;
    logic                w_gnt_valid;
    logic                w_gnt_idx;
    logic                w_mem_we;
    logic                w_done0;
    logic                w_done1;

    assign w_req = {bus.p1_go, bus.p0_go};

    std_rr_arb2 u_rr (
        .req       (w_req),
        .prio      (r_prio),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    // Next state and outputs. go is only looked at in IDLE, and mem_done
    // only in WAIT_W, so stray done pulses elsewhere have no effect.
    always_comb begin
        w_next_state = r_state;
        w_mem_we     = 1'b0;
        w_done0      = 1'b0;
        w_done1      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                w_mem_we     = r_op;
                w_next_state = r_op ? WAIT_W : DONE;
            end
            WAIT_W: begin
                if (bus.mem_done) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_done0      = ~r_owner;
                w_done1      = r_owner;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_prio   <= 1'b0;
            r_owner  <= 1'b0;
            r_op     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_state <= w_next_state;

            if (r_state == IDLE && w_gnt_valid) begin
                r_owner <= w_gnt_idx;
                r_op    <= w_gnt_idx ? bus.p1_write_en   : bus.p0_write_en;
                r_addr  <= w_gnt_idx ? bus.p1_addr0      : bus.p0_addr0;
                r_wdata <= w_gnt_idx ? bus.p1_write_data : bus.p0_write_data;
            end

            // Memory read is combinational on the latched address.
            if (r_state == ACCESS && !r_op) begin
                if (r_owner) begin
                    r_rdata1 <= bus.mem_read_data;
                end else begin
                    r_rdata0 <= bus.mem_read_data;
                end
            end

            // Last winner loses the next tie.
            if (r_state == DONE) begin
                r_prio <= ~r_owner;
            end
        end
    end

    // Memory side is driven only from latched state, never from clients.
    assign bus.mem_addr0      = r_addr;
    assign bus.mem_write_data = r_wdata;
    assign bus.mem_write_en   = w_mem_we;
    assign bus.p0_done        = w_done0;
    assign bus.p1_done        = w_done1;
    assign bus.p0_read_data   = r_rdata0;
    assign bus.p1_read_data   = r_rdata1;

endmodule : std_mem_d1_arbiter
`default_nettype wire

// File: tb/tb_std_mem_d1_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_std_mem_d1_arbiter
//  Description : Self-checking bench for std_mem_d1_arbiter with a
//                behavioural std_mem_d1 and a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_std_mem_d1_arbiter;

    localparam int WIDTH    = 32;
    localparam int IDX_SIZE = 4;
    localparam int DEPTH    = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    std_mem_d1_arbiter_if #(.WIDTH(WIDTH), .IDX_SIZE(IDX_SIZE)) bus ();

    std_mem_d1_arbiter #(.WIDTH(WIDTH), .SIZE(DEPTH), .IDX_SIZE(IDX_SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural std_mem_d1: combinational read, registered write + done.
    logic [WIDTH-1:0] mem_arr [DEPTH];
    logic             mem_done_q = 1'b0;
    logic             stray_done = 1'b0;
    logic             preload    = 1'b0;

    always @(posedge clk) begin
        mem_done_q <= bus.mem_write_en;
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem_arr[i] <= 32'(i * 17);
        end else if (bus.mem_write_en) begin
            mem_arr[bus.mem_addr0] <= bus.mem_write_data;
        end
    end

    assign bus.mem_read_data = mem_arr[bus.mem_addr0];
    assign bus.mem_done      = mem_done_q | stray_done;

    logic [2:0] ctl;   // {p0_done, p1_done, mem_write_en}
    assign ctl = {bus.p0_done, bus.p1_done, bus.mem_write_en};

    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] exp_rd  [2];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int c, input logic go, input logic we,
                         input logic [IDX_SIZE-1:0] a, input logic [WIDTH-1:0] d);
        if (c == 0) begin
            bus.p0_go = go; bus.p0_write_en = we; bus.p0_addr0 = a; bus.p0_write_data = d;
        end else begin
            bus.p1_go = go; bus.p1_write_en = we; bus.p1_addr0 = a; bus.p1_write_data = d;
        end
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        reset   = 1'b0;
        preload = 1'b1;
        step();
        preload = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i * 17);
        step();
        n_cmp++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL reset_ctl got=%b exp=000", ctl); end
        n_cmp++; if (bus.p0_read_data !== '0) begin n_fail++; $display("FAIL reset_rd0 got=%h exp=0", bus.p0_read_data); end
        n_cmp++; if (bus.p1_read_data !== '0) begin n_fail++; $display("FAIL reset_rd1 got=%h exp=0", bus.p1_read_data); end
        n_cmp++; if (bus.mem_addr0 !== '0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr0); end
        n_cmp++; if (bus.mem_write_data !== '0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", bus.mem_write_data); end
        reset = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // p0 writes DEADBEEF to 5 (done at t+3) then reads it back (done at t+2).
    task automatic test_write_read();
        drive(0, 1'b1, 1'b1, 4'd5, 32'hDEADBEEF);
        step();
        n_cmp++; if (ctl !== 3'b001) begin n_fail++; $display("FAIL wr_access_ctl got=%b exp=001", ctl); end
        n_cmp++; if (bus.mem_addr0 !== 4'd5) begin n_fail++; $display("FAIL wr_addr got=%h exp=5", bus.mem_addr0); end
        n_cmp++; if (bus.mem_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_data got=%h exp=deadbeef", bus.mem_write_data); end
        step();
        n_cmp++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL wr_wait_ctl got=%b exp=000", ctl); end
        n_cmp++; if (bus.mem_addr0 !== 4'd5) begin n_fail++; $display("FAIL wr_wait_addr got=%h exp=5", bus.mem_addr0); end
        step();
        n_cmp++; if (ctl !== 3'b100) begin n_fail++; $display("FAIL wr_done_ctl got=%b exp=100", ctl); end
        ref_mem[5] = 32'hDEADBEEF;
        step();
        drive(0, 1'b1, 1'b0, 4'd5, '0);
        step();
        n_cmp++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL rd_access_ctl got=%b exp=000", ctl); end
        step();
        n_cmp++; if (ctl !== 3'b100) begin n_fail++; $display("FAIL rd_done_ctl got=%b exp=100", ctl); end
        n_cmp++; if (bus.p0_read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=deadbeef", bus.p0_read_data); end
        exp_rd[0] = 32'hDEADBEEF;
        drive(0, 1'b0, 1'b0, '0, '0);
        step();
    endtask

    // Tie right after reset: p0 first (t+2), p1 next (t+5).
    task automatic test_simultaneous();
        reset = 1'b0;
        step();
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 4'd1, '0);
        drive(1, 1'b1, 1'b0, 4'd2, '0);
        step();
        n_cmp++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL sim_t1 got=%b exp=000", ctl); end
        step();
        n_cmp++; if (ctl !== 3'b100) begin n_fail++; $display("FAIL sim_t2 got=%b exp=100", ctl); end
        n_cmp++; if (bus.p0_read_data !== 32'h11) begin n_fail++; $display("FAIL sim_rd0 got=%h exp=11", bus.p0_read_data); end
        step();
        drive(0, 1'b0, 1'b0, '0, '0);
        n_cmp++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL sim_t3 got=%b exp=000", ctl); end
        step();
        n_cmp++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL sim_t4 got=%b exp=000", ctl); end
        step();
        n_cmp++; if (ctl !== 3'b010) begin n_fail++; $display("FAIL sim_t5 got=%b exp=010", ctl); end
        n_cmp++; if (bus.p1_read_data !== 32'h22) begin n_fail++; $display("FAIL sim_rd1 got=%h exp=22", bus.p1_read_data); end
        exp_rd[0] = 32'h11;
        exp_rd[1] = 32'h22;
        drive(1, 1'b0, 1'b0, '0, '0);
        step();
    endtask

    // Both hold go; last winner was p1, so order is 0,1,0,1,0,1.
    task automatic test_fairness();
        logic [IDX_SIZE-1:0] a [2];
        int got = 0;
        int cyc = 0;
        a[0] = IDX_SIZE'($urandom_range(0, DEPTH - 1));
        a[1] = IDX_SIZE'($urandom_range(0, DEPTH - 1));
        drive(0, 1'b1, 1'b0, a[0], '0);
        drive(1, 1'b1, 1'b0, a[1], '0);
        while (got < 6 && cyc < 40) begin
            step();
            cyc++;
            if (bus.p0_done || bus.p1_done) begin
                int w;
                w = bus.p1_done ? 1 : 0;
                n_cmp++; if (bus.p0_done && bus.p1_done) begin n_fail++; $display("FAIL fair_both_done got=11 exp=one-hot"); end
                n_cmp++; if (w != (got % 2)) begin n_fail++; $display("FAIL fair_order idx=%0d got=%0d exp=%0d", got, w, got % 2); end
                exp_rd[w] = ref_mem[a[w]];
                n_cmp++;
                if ((w == 0 ? bus.p0_read_data : bus.p1_read_data) !== exp_rd[w]) begin
                    n_fail++; $display("FAIL fair_rdata client=%0d got=%h exp=%h", w,
                                       (w == 0 ? bus.p0_read_data : bus.p1_read_data), exp_rd[w]);
                end
                got++;
                a[w] = IDX_SIZE'($urandom_range(0, DEPTH - 1));
                drive(w, 1'b1, 1'b0, a[w], '0);
            end
        end
        n_cmp++; if (got != 6) begin n_fail++; $display("FAIL fair_timeout got=%0d exp=6", got); end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        step();
    endtask

    // p1 alone, 3 back-to-back reads: with prio=0 first, then prio=1.
    task automatic test_lone();
        for (int ph = 0; ph < 2; ph++) begin
            logic [IDX_SIZE-1:0] a;
            if (ph == 1) begin
                drive(0, 1'b1, 1'b0, 4'd3, '0);
                step();
                step();
                n_cmp++; if (ctl !== 3'b100) begin n_fail++; $display("FAIL lone_p0_done got=%b exp=100", ctl); end
                exp_rd[0] = ref_mem[3];
                drive(0, 1'b0, 1'b0, '0, '0);
                step();
            end
            a = IDX_SIZE'($urandom_range(0, DEPTH - 1));
            drive(1, 1'b1, 1'b0, a, '0);
            for (int k = 1; k <= 9; k++) begin
                logic exp_d;
                step();
                exp_d = ((k % 3) == 2);
                n_cmp++;
                if (ctl !== {1'b0, exp_d, 1'b0}) begin
                    n_fail++; $display("FAIL lone_ctl ph=%0d k=%0d got=%b exp=%b", ph, k, ctl, {1'b0, exp_d, 1'b0});
                end
                if (exp_d) begin
                    exp_rd[1] = ref_mem[a];
                    n_cmp++; if (bus.p1_read_data !== exp_rd[1]) begin n_fail++; $display("FAIL lone_rdata got=%h exp=%h", bus.p1_read_data, exp_rd[1]); end
                    a = IDX_SIZE'($urandom_range(0, DEPTH - 1));
                    drive(1, (k != 8), 1'b0, a, '0);
                end
            end
        end
    endtask

    // mem_done forced high in IDLE and through a read access.
    task automatic test_stray_done();
        stray_done = 1'b1;
        step();
        n_cmp++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL stray_idle1 got=%b exp=000", ctl); end
        step();
        n_cmp++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL stray_idle2 got=%b exp=000", ctl); end
        drive(0, 1'b1, 1'b0, 4'd7, '0);
        step();
        n_cmp++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL stray_access got=%b exp=000", ctl); end
        step();
        n_cmp++; if (ctl !== 3'b100) begin n_fail++; $display("FAIL stray_done got=%b exp=100", ctl); end
        exp_rd[0] = ref_mem[7];
        n_cmp++; if (bus.p0_read_data !== exp_rd[0]) begin n_fail++; $display("FAIL stray_rdata got=%h exp=%h", bus.p0_read_data, exp_rd[0]); end
        drive(0, 1'b0, 1'b0, '0, '0);
        step();
        n_cmp++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL stray_after got=%b exp=000", ctl); end
        stray_done = 1'b0;
    endtask

    // Reset during WAIT_W: no done, outputs cleared, write still committed.
    task automatic test_reset_mid_write();
        drive(0, 1'b1, 1'b1, 4'd9, 32'hCAFEF00D);
        step();
        n_cmp++; if (ctl !== 3'b001) begin n_fail++; $display("FAIL mid_access got=%b exp=001", ctl); end
        step();
        n_cmp++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL mid_wait got=%b exp=000", ctl); end
        reset = 1'b0;
        step();
        n_cmp++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL mid_ctl got=%b exp=000", ctl); end
        n_cmp++; if (bus.p0_read_data !== '0) begin n_fail++; $display("FAIL mid_rd0 got=%h exp=0", bus.p0_read_data); end
        n_cmp++; if (bus.p1_read_data !== '0) begin n_fail++; $display("FAIL mid_rd1 got=%h exp=0", bus.p1_read_data); end
        n_cmp++; if (bus.mem_addr0 !== '0) begin n_fail++; $display("FAIL mid_addr got=%h exp=0", bus.mem_addr0); end
        n_cmp++; if (bus.mem_write_data !== '0) begin n_fail++; $display("FAIL mid_wdata got=%h exp=0", bus.mem_write_data); end
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        ref_mem[9] = 32'hCAFEF00D;
        step();
        n_cmp++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL mid_idle got=%b exp=000", ctl); end
        drive(0, 1'b1, 1'b0, 4'd9, '0);
        step();
        step();
        n_cmp++; if (ctl !== 3'b100) begin n_fail++; $display("FAIL mid_rb_done got=%b exp=100", ctl); end
        n_cmp++; if (bus.p0_read_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mid_rb_data got=%h exp=cafef00d", bus.p0_read_data); end
        exp_rd[0] = 32'hCAFEF00D;
        drive(0, 1'b0, 1'b0, '0, '0);
        step();
    endtask

    // Random traffic against a transaction-level scheduler: an idle arbiter
    // picks a pending client (tie -> prio), read done 2 cycles later, write
    // done 3 cycles later, and is free again the cycle after done.
    task automatic test_random(input int n);
        logic                pend [2];
        logic                saw  [2];
        logic                cop  [2];
        logic [IDX_SIZE-1:0] caddr [2];
        logic [WIDTH-1:0]    cdata [2];
        logic                m_busy = 1'b0;
        logic                m_owner = 1'b0;
        logic                m_op = 1'b0;
        logic [IDX_SIZE-1:0] m_addr = '0;
        logic [WIDTH-1:0]    m_wd = '0;
        logic                m_prio = 1'b1;   // last winner was p0 (read-back above)
        int acc_at = -1, done_at = -1, free_at = 0;
        int c = 0;
        for (int i = 0; i < 2; i++) begin pend[i] = 1'b0; saw[i] = 1'b0; end
        while (c < n + 20) begin
            logic [2:0] exp_ctl;
            step();
            for (int i = 0; i < 2; i++) begin
                if (saw[i]) begin pend[i] = 1'b0; saw[i] = 1'b0; end
                if (!pend[i] && c < n && $urandom_range(0, 99) < 40) begin
                    pend[i]  = 1'b1;
                    cop[i]   = ($urandom_range(0, 1) == 1);
                    caddr[i] = IDX_SIZE'($urandom_range(0, DEPTH - 1));
                    cdata[i] = $urandom;
                end
                drive(i, pend[i], pend[i] ? cop[i] : 1'b0, pend[i] ? caddr[i] : '0, pend[i] ? cdata[i] : '0);
            end
            exp_ctl = {m_busy && c == done_at && !m_owner,
                       m_busy && c == done_at && m_owner,
                       m_busy && m_op && c == acc_at};
            if (m_busy && c == done_at && !m_op) exp_rd[m_owner] = ref_mem[m_addr];
            n_cmp++; if (ctl !== exp_ctl) begin n_fail++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", c, ctl, exp_ctl); end
            n_cmp++; if (bus.p0_read_data !== exp_rd[0]) begin n_fail++; $display("FAIL rnd_rd0 cyc=%0d got=%h exp=%h", c, bus.p0_read_data, exp_rd[0]); end
            n_cmp++; if (bus.p1_read_data !== exp_rd[1]) begin n_fail++; $display("FAIL rnd_rd1 cyc=%0d got=%h exp=%h", c, bus.p1_read_data, exp_rd[1]); end
            if (m_busy && c == acc_at) begin
                n_cmp++; if (bus.mem_addr0 !== m_addr) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, bus.mem_addr0, m_addr); end
                if (m_op) begin
                    n_cmp++; if (bus.mem_write_data !== m_wd) begin n_fail++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", c, bus.mem_write_data, m_wd); end
                end
            end
            if (m_busy && c == done_at) begin
                if (m_op) ref_mem[m_addr] = m_wd;
                saw[m_owner] = 1'b1;
                m_prio = ~m_owner;
                m_busy = 1'b0;
            end
            if (!m_busy && c >= free_at && (pend[0] || pend[1])) begin
                m_owner = (pend[0] && pend[1]) ? m_prio : pend[1];
                m_op    = cop[m_owner];
                m_addr  = caddr[m_owner];
                m_wd    = cdata[m_owner];
                acc_at  = c + 1;
                done_at = c + (m_op ? 3 : 2);
                free_at = done_at + 1;
                m_busy  = 1'b1;
            end
            c++;
            if (c >= n && !pend[0] && !pend[1] && !m_busy) break;
        end
        n_cmp++; if (pend[0] || pend[1] || m_busy) begin n_fail++; $display("FAIL rnd_drain_timeout got=pending exp=idle"); end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_fairness();
        test_lone();
        test_stray_done();
        test_reset_mid_write();
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_std_mem_d1_arbiter
`default_nettype wire

// File: doc/std_mem_d1_arbiter.md
Name: std_mem_d1_arbiter

Overview:
- Two-requester, round-robin arbiter that shares one single-ported std_mem_d1 instance between two Calyx-style go/done clients.
- Each client issues a one-word read or write.
- The arbiter grants the memory to one client and sequences the access:
  - reads: the combinational read is captured into a register;
  - writes: the write is held until the memory's registered done.
- The arbiter then returns a one-cycle done to that client.
- Sits between compiler-generated control groups and a std_mem_d1 whose ports it drives exclusively.

Parameters:
width, 32, data word width (matches memory width)
size, 16, memory depth (informational; not used in logic)
idx_size, 4, address width (matches memory idx_size)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
p0_go  input  1  client 0 request; held high until p0_done seen
p0_write_en  input  1  client 0 op: 1 = write, 0 = read
p0_addr0  input  idx_size  client 0 address
p0_write_data  input  width  client 0 write data
p0_read_data  output  width  client 0 read result (registered)
p0_done  output  1  client 0 completion pulse
p1_go, p1_write_en, p1_addr0, p1_write_data, p1_read_data, p1_done  (same as client 0, for client 1)
mem_addr0  output  idx_size  to memory addr0
mem_write_data  output  width  to memory write_data
mem_write_en  output  1  to memory write_en
mem_read_data  input  width  from memory read_data (combinational)
mem_done  input  1  from memory done (registered, one cycle after write_en)

Behaviour:
- Reset values (reset==0 at clk edge):
  - state=IDLE, prio=0;
  - mem_write_en=0, p0_done=p1_done=0;
  - p0/p1_read_data=0;
  - latched addr/data/op/owner=0.
- FSM states: IDLE, ACCESS, WAIT_W, DONE.
- IDLE:
  - If no go is high, stay.
  - If exactly one go is high, grant that client.
  - If both are high, grant client prio.
  - On grant: latch owner, op, addr, wdata; go to ACCESS.
  - go is sampled only in IDLE.
- ACCESS (one cycle):
  - mem_addr0 = latched addr.
  - Read: capture mem_read_data into owner's read_data at the edge; go to DONE.
  - Write: mem_write_en=1, mem_write_data = latched wdata; go to WAIT_W.
- WAIT_W:
  - mem_write_en=0; addr/data held stable.
  - Stay until mem_done==1, then go to DONE. No timeout.
- DONE (one cycle):
  - owner's done=1; the other client's done=0.
  - prio <= ~owner (the loser of the next tie is the last winner).
  - Go to IDLE.
- Latency (go rise in cycle t, arbiter idle):
  - read: done in cycle t+2;
  - write: done in cycle t+3.
  - Minimum idle gap between grants: 1 cycle (the IDLE cycle).
- Output rules:
  - mem_addr0 and mem_write_data are always driven from latched registers, never from client ports directly.
  - mem_write_en is high only in ACCESS with a write op; exactly one cycle per write.
  - read_data holds its value until that client's next read completes; writes do not modify it.
- A client whose go is low during IDLE is not granted. A go that drops before done is a protocol violation; the access still completes.
- The next request is taken from the go level seen in IDLE after DONE. A client holding go high continuously is re-served, alternating with the other client if both are pending.
- Reset mid-operation:
  - FSM returns to IDLE and no done is emitted.
  - A write already issued in ACCESS commits in the memory. The arbiter ignores the stray mem_done.
- mem_done outside WAIT_W is ignored.
- No width conversion: addr and data pass through at parameter widths.

Decomposition:
- Package std_arb_pkg: typedef enum logic [1:0] arb_state_t {IDLE, ACCESS, WAIT_W, DONE}; localparam NUM_REQ = 2.
- Sub-module std_rr_arb2:
  - inputs: req[1:0], prio;
  - outputs: gnt_valid, gnt_idx.
  - Purely combinational priority pick. The top level owns the prio register and the FSM.

Test Plan:
- Write then read, client 0 (width=32, idx_size=4): p0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> write done at t+3 with exactly one mem_write_en pulse; read done at t+2 with p0_read_data=0xDEADBEEF.
- Simultaneous reads after reset (prio=0), both go high in the same cycle, p0 addr 1 (=0x11), p1 addr 2 (=0x22):
  - p0_done first at t+2;
  - p1 granted in the following IDLE, p1_done at t+5;
  - read_data 0x11 and 0x22 respectively.
- Fairness: both clients hold go high continuously for 6 accesses -> grant order 0,1,0,1,0,1; no client served twice consecutively.
- Lone requester: only p1 requests 3 back-to-back reads while prio=1 and again while prio=0 -> each granted immediately; done every 3 cycles.
- Reset mid-write: assert reset low in the WAIT_W cycle -> no p*_done; next cycle state=IDLE and all outputs at reset values; a subsequent read of that addr returns the written data.
- Stray mem_done: force mem_done=1 while in IDLE and in ACCESS-read -> no state change beyond the normal flow; no spurious done.
